// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// message codes, active-low glyph constants, glyph index enum and helpers.
package disp_pkg;

  localparam logic [1:0] MSG_NUM = 2'b00;
  localparam logic [1:0] MSG_OP  = 2'b01;
  localparam logic [1:0] MSG_VAL = 2'b10;
  localparam logic [1:0] MSG_ERR = 2'b11;

  // Active-low segments {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_V     = 8'hC1;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [4:0] {
    GI_0, GI_1, GI_2, GI_3, GI_4, GI_5, GI_6, GI_7, GI_8, GI_9,
    GI_DASH, GI_O, GI_R, GI_E, GI_P, GI_V, GI_A, GI_L, GI_BLANK
  } glyph_e;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  function automatic logic [7:0] glyph_seg(input glyph_e g);
    logic [7:0] s;
    case (g)
      GI_0:    s = SEG_0;
      GI_1:    s = SEG_1;
      GI_2:    s = SEG_2;
      GI_3:    s = SEG_3;
      GI_4:    s = SEG_4;
      GI_5:    s = SEG_5;
      GI_6:    s = SEG_6;
      GI_7:    s = SEG_7;
      GI_8:    s = SEG_8;
      GI_9:    s = SEG_9;
      GI_DASH: s = SEG_DASH;
      GI_O:    s = SEG_O;
      GI_R:    s = SEG_R;
      GI_E:    s = SEG_E;
      GI_P:    s = SEG_P;
      GI_V:    s = SEG_V;
      GI_A:    s = SEG_A;
      GI_L:    s = SEG_L;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // pos counts from the leftmost (sign) digit: 0 = NDIG-1, 1 = NDIG-2, 2 = NDIG-3
  function automatic glyph_e msg_glyph(input logic [1:0] m, input int unsigned pos);
    glyph_e g;
    g = GI_BLANK;
    case (m)
      MSG_OP:  case (pos) 0: g = GI_O; 1: g = GI_P; default: g = GI_BLANK; endcase
      MSG_VAL: case (pos) 0: g = GI_V; 1: g = GI_A; 2: g = GI_L; default: g = GI_BLANK; endcase
      MSG_ERR: case (pos) 0: g = GI_E; 1: g = GI_R; 2: g = GI_R; default: g = GI_BLANK; endcase
      default: g = GI_BLANK;
    endcase
    return g;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seq_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle over
// NDIG nibbles (top nibble = overflow), with a one-cycle commit/done state.
module seq_bin2bcd import disp_pkg::*; #(
  parameter int unsigned BIN_W = 8,
  parameter int unsigned NDIG  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int unsigned CW = $clog2(BIN_W);

  conv_state_e       state, state_nx;
  logic [CW-1:0]     cnt;
  logic [BIN_W-1:0]  sh;
  logic [4*NDIG-1:0] acc, acc_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CONV_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CONV_IDLE:   if (start) state_nx = CONV_SHIFT;
      CONV_SHIFT:  if (cnt == CW'(BIN_W - 1)) state_nx = CONV_COMMIT;
      CONV_COMMIT: state_nx = CONV_IDLE;
      default:     state_nx = CONV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != CONV_IDLE);
    done = (state == CONV_COMMIT);
  end

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < NDIG; i++)
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
      acc <= '0;
    end else if (state == CONV_IDLE && start) begin
      cnt <= '0;
      sh  <= bin;
      acc <= '0;
    end else if (state == CONV_SHIFT) begin
      cnt <= cnt + CW'(1);
      sh  <= {sh[BIN_W-2:0], 1'b0};
      acc <= {acc_adj[4*NDIG-2:0], sh[BIN_W-1]};
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed NDIG-digit common-anode 7-segment controller with BCD conversion,
// overflow dashes, message words and a busy handshake. Define DISP_LZB_EN for
// leading-zero blanking with a floating minus sign.
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned DIG_PERIOD = 262144
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enable,
  input  logic                    display_sel,
  input  logic [BIN_W-1:0]        bin,
  input  logic                    sgn,
  input  logic [$clog2(NDIG)-1:0] dot,
  input  logic [1:0]              msg,
  output logic                    busy,
  output logic [NDIG-1:0]         disp_select,
  output logic [7:0]              disp_value
);

  localparam int unsigned     DW       = $clog2(NDIG);
  localparam int unsigned     PW       = $clog2(DIG_PERIOD);
  localparam int unsigned     MW       = 4 * (NDIG - 1);
  localparam longint unsigned MAX_MAG  = pow10(NDIG - 1) - 1;
  localparam logic [DW-1:0]   SIGN_IDX = DW'(NDIG - 1);

  logic              load, done;
  logic [4*NDIG-1:0] conv_bcd;
  logic              sh_sgn, sh_ovf;
  logic [DW-1:0]     sh_dot;
  logic [1:0]        sh_msg;
  logic [MW-1:0]     d_bcd;
  logic              d_sgn, d_ovf;
  logic [DW-1:0]     d_dot;
  logic [1:0]        d_msg;
  logic [PW-1:0]     scan_cnt;
  logic [DW-1:0]     idx;
  logic [3:0]        nib;
  logic [DW-1:0]     sign_pos;
  logic              lead_blank;
  glyph_e            gi;
  logic              dp_on;

  assign load = wr_enable & display_sel & ~busy;

  seq_bin2bcd #(.BIN_W(BIN_W), .NDIG(NDIG)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_sgn <= 1'b0;
      sh_ovf <= 1'b0;
      sh_dot <= '0;
      sh_msg <= MSG_NUM;
    end else if (load) begin
      sh_sgn <= sgn;
      sh_ovf <= (64'(bin) > MAX_MAG);
      sh_dot <= dot;
      sh_msg <= msg;
    end
  end

  // The overflow nibble alone can wrap for wide BIN_W, hence the compare captured at load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_bcd <= '0;
      d_sgn <= 1'b0;
      d_ovf <= 1'b0;
      d_dot <= '0;
      d_msg <= MSG_NUM;
    end else if (done) begin
      d_bcd <= conv_bcd[MW-1:0];
      d_sgn <= sh_sgn;
      d_ovf <= sh_ovf | (conv_bcd[4*NDIG-1 -: 4] != 4'd0);
      d_dot <= sh_dot;
      d_msg <= sh_msg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (done) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == PW'(DIG_PERIOD - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == SIGN_IDX) ? '0 : idx + DW'(1);
    end else begin
      scan_cnt <= scan_cnt + PW'(1);
    end
  end

  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < NDIG - 1; i++)
      if (idx == DW'(i)) nib = d_bcd[4*i +: 4];
  end

`ifdef DISP_LZB_EN
  logic [DW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < NDIG - 1; i++)
      if (d_bcd[4*i +: 4] != 4'd0) msd = DW'(i);
    sign_pos = msd + DW'(1);
    // A DP-forced zero already fills the slot left of the value; the sign then stays home
    if (d_ovf || sign_pos == d_dot) sign_pos = SIGN_IDX;
    lead_blank = (idx != SIGN_IDX) && (idx > msd) && (idx != d_dot);
  end
`else
  assign sign_pos   = SIGN_IDX;
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    gi    = GI_BLANK;
    dp_on = 1'b0;
    if (d_msg != MSG_NUM) begin
      gi = msg_glyph(d_msg, (NDIG - 1) - 32'(idx));
    end else begin
      if (idx == SIGN_IDX)  gi = (d_sgn && sign_pos == SIGN_IDX) ? GI_DASH : GI_BLANK;
      else if (d_ovf)       gi = GI_DASH;
      else if (lead_blank)  gi = (d_sgn && idx == sign_pos) ? GI_DASH : GI_BLANK;
      else                  gi = glyph_e'({1'b0, nib});
      dp_on = (d_dot != '0) && (d_dot == idx) && !(d_ovf && idx != SIGN_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_select <= {{(NDIG-1){1'b1}}, 1'b0};
      disp_value  <= SEG_0;
    end else begin
      disp_select <= ~(NDIG'(1) << idx);
      disp_value  <= glyph_seg(gi) & {~dp_on, 7'h7F};
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: two instances (8-bit and 12-bit
// magnitude) checked against a decimal-arithmetic reference of the display.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  localparam int ND   = 4;
  localparam int DP   = 4;
  localparam int NCAP = 5 * DP;
`ifdef DISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_a, wr_b, display_sel, sgn;
  logic [7:0]  bin_a;
  logic [11:0] bin_b;
  logic [1:0]  dot, msg;
  logic        busy_a, busy_b;
  logic [3:0]  sel_a, sel_b;
  logic [7:0]  val_a, val_b;

  int checks = 0;
  int fails  = 0;

  logic [3:0]  cap_sel [NCAP];
  logic [7:0]  cap_val [NCAP];
  int unsigned last_bin [2];
  bit          last_sgn [2];
  int unsigned last_dot [2];
  int unsigned last_msg [2];

  always #5 clk = ~clk;

  disp_scan_ctrl #(.NDIG(4), .BIN_W(8), .DIG_PERIOD(4)) u_dut_a (
    .clk(clk), .rst(rst), .wr_enable(wr_a), .display_sel(display_sel),
    .bin(bin_a), .sgn(sgn), .dot(dot), .msg(msg),
    .busy(busy_a), .disp_select(sel_a), .disp_value(val_a)
  );

  disp_scan_ctrl #(.NDIG(4), .BIN_W(12), .DIG_PERIOD(4)) u_dut_b (
    .clk(clk), .rst(rst), .wr_enable(wr_b), .display_sel(display_sel),
    .bin(bin_b), .sgn(sgn), .dot(dot), .msg(msg),
    .busy(busy_b), .disp_select(sel_b), .disp_value(val_b)
  );

  function automatic int unsigned p10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] digit_seg(input int unsigned v);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[v];
  endfunction

  // Expected segments of digit d for a committed (bin, sgn, dot, msg)
  function automatic logic [7:0] model_seg(input int d, input int unsigned b, input bit s,
                                           input int unsigned dt, input int unsigned m);
    logic [7:0]  seg;
    logic [7:0]  word [3];
    bit          ovf;
    int unsigned width, sp;
    if (m != 0) begin
      case (m)
        1:       word = '{8'hC0, 8'h8C, 8'hFF};
        2:       word = '{8'hC1, 8'h88, 8'hC7};
        default: word = '{8'h86, 8'hAF, 8'hAF};
      endcase
      return (d >= ND - 3) ? word[ND-1-d] : 8'hFF;
    end
    ovf   = (b > p10(ND - 1) - 1);
    width = 1;
    while (width < ND - 1 && b >= p10(width)) width++;
    sp = ND - 1;
    if (LZB && !ovf && width != dt) sp = width;
    if (d == ND - 1)                                   seg = (s && sp == ND - 1) ? 8'hBF : 8'hFF;
    else if (ovf)                                      seg = 8'hBF;
    else if (LZB && d >= int'(width) && d != int'(dt)) seg = (s && d == int'(sp)) ? 8'hBF : 8'hFF;
    else                                               seg = digit_seg((b / p10(d)) % 10);
    if (dt != 0 && d == int'(dt) && !(ovf && d != ND - 1)) seg = seg & 8'h7F;
    return seg;
  endfunction

  task automatic do_load(input bit on_b, input int unsigned b, input bit s,
                         input int unsigned dt, input int unsigned m);
    @(negedge clk);
    bin_a = 8'(b); bin_b = 12'(b);
    sgn = s; dot = 2'(dt); msg = 2'(m); display_sel = 1'b1;
    if (on_b) wr_b = 1'b1; else wr_a = 1'b1;
    @(negedge clk);
    wr_a = 1'b0; wr_b = 1'b0;
  endtask

  task automatic capture(input bit on_b);
    for (int n = 0; n < NCAP; n++) begin
      @(negedge clk);
      cap_sel[n] = on_b ? sel_b : sel_a;
      cap_val[n] = on_b ? val_b : val_a;
    end
  endtask

  task automatic test_reset();
    logic [3:0] es;
    logic [7:0] ev;
    rst = 1'b1; wr_a = 1'b0; wr_b = 1'b0; display_sel = 1'b0;
    bin_a = '0; bin_b = '0; sgn = 1'b0; dot = '0; msg = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
    checks++; if (sel_a !== 4'b1110) begin fails++; $display("FAIL reset_select: got %b, expected 1110", sel_a); end
    checks++; if (val_a !== 8'hC0)   begin fails++; $display("FAIL reset_value: got %h, expected c0", val_a); end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_bin[i] = 0; last_sgn[i] = 0; last_dot[i] = 0; last_msg[i] = 0;
    end
    capture(1'b0);
    for (int k = 0; k < NCAP; k++) begin
      es = ~(4'b0001 << ((k / DP) % ND));
      ev = model_seg((k / DP) % ND, 0, 0, 0, 0);
      checks++; if (cap_sel[k] !== es) begin fails++; $display("FAIL reset_scan_sel[%0d]: got %b, expected %b", k, cap_sel[k], es); end
      checks++; if (cap_val[k] !== ev) begin fails++; $display("FAIL reset_scan_val[%0d]: got %h, expected %h", k, cap_val[k], ev); end
    end
  endtask

  task automatic test_load(input string name, input bit on_b, input int unsigned b, input bit s,
                           input int unsigned dt, input int unsigned m);
    int         n;
    int         eb;
    logic [3:0] es;
    logic [7:0] ev;
    eb = on_b ? 13 : 9;
    do_load(on_b, b, s, dt, m);
    n = 0;
    while ((on_b ? busy_b : busy_a) && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != eb) begin fails++; $display("FAIL %s busy_cycles: got %0d, expected %0d", name, n, eb); end
    last_bin[on_b] = b; last_sgn[on_b] = s; last_dot[on_b] = dt; last_msg[on_b] = m;
    capture(on_b);
    for (int k = 0; k < NCAP; k++) begin
      es = ~(4'b0001 << ((k / DP) % ND));
      ev = model_seg((k / DP) % ND, b, s, dt, m);
      checks++; if (cap_sel[k] !== es) begin fails++; $display("FAIL %s sel[%0d]: got %b, expected %b", name, k, cap_sel[k], es); end
      checks++; if (cap_val[k] !== ev) begin fails++; $display("FAIL %s val[%0d]: got %h, expected %h", name, k, cap_val[k], ev); end
    end
  endtask

  task automatic test_busy_drop();
    int         n, d;
    logic [3:0] es;
    logic [7:0] ev;
    do_load(1'b0, 100, 1'b0, 2, 0);
    n = 0;
    while (busy_a && n < 100) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (!sel_a[i]) d = i;
      ev = model_seg(d, last_bin[0], last_sgn[0], last_dot[0], last_msg[0]);
      checks++; if (val_a !== ev) begin fails++; $display("FAIL hold_during_busy[%0d]: got %h, expected %h", n, val_a, ev); end
      if (n == 2) begin bin_a = 8'd3; sgn = 1'b1; dot = 2'd1; msg = 2'b11; wr_a = 1'b1; end
      else wr_a = 1'b0;
      n++;
      @(negedge clk);
    end
    wr_a = 1'b0;
    checks++; if (n != 9) begin fails++; $display("FAIL busy_drop busy_cycles: got %0d, expected 9", n); end
    last_bin[0] = 100; last_sgn[0] = 0; last_dot[0] = 2; last_msg[0] = 0;
    capture(1'b0);
    for (int k = 0; k < NCAP; k++) begin
      es = ~(4'b0001 << ((k / DP) % ND));
      ev = model_seg((k / DP) % ND, 100, 0, 2, 0);
      checks++; if (cap_sel[k] !== es) begin fails++; $display("FAIL busy_drop sel[%0d]: got %b, expected %b", k, cap_sel[k], es); end
      checks++; if (cap_val[k] !== ev) begin fails++; $display("FAIL busy_drop val[%0d]: got %h, expected %h", k, cap_val[k], ev); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] es;
    logic [7:0] ev;
    do_load(1'b0, 200, 1'b1, 3, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL midreset_busy: got %b, expected 0", busy_a); end
    checks++; if (sel_a !== 4'b1110) begin fails++; $display("FAIL midreset_select: got %b, expected 1110", sel_a); end
    checks++; if (val_a !== 8'hC0)   begin fails++; $display("FAIL midreset_value: got %h, expected c0", val_a); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_bin[i] = 0; last_sgn[i] = 0; last_dot[i] = 0; last_msg[i] = 0;
    end
    capture(1'b0);
    for (int k = 0; k < NCAP; k++) begin
      es = ~(4'b0001 << ((k / DP) % ND));
      ev = model_seg((k / DP) % ND, 0, 0, 0, 0);
      checks++; if (cap_sel[k] !== es) begin fails++; $display("FAIL midreset sel[%0d]: got %b, expected %b", k, cap_sel[k], es); end
      checks++; if (cap_val[k] !== ev) begin fails++; $display("FAIL midreset val[%0d]: got %h, expected %h", k, cap_val[k], ev); end
    end
  endtask

  task automatic test_random();
    int unsigned b, dt, m;
    bit          s, on_b;
    for (int i = 0; i < 18; i++) begin
      on_b = (i % 3 == 2);
      b    = on_b ? $urandom_range(0, 4095) : $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 12);
      s    = 1'($urandom_range(0, 1));
      dt   = $urandom_range(0, 3);
      m    = $urandom_range(0, 7);
      if (m > 3) m = 0;
      test_load($sformatf("random%0d", i), on_b, b, s, dt, m);
    end
  endtask

  initial begin
    test_reset();
    test_load("bin255",     1'b0, 255, 1'b0, 0, 0);
    test_load("bin7_neg",   1'b0, 7,   1'b1, 1, 0);
    test_load("msg_err",    1'b0, 37,  1'b1, 2, 3);
    test_load("msg_op",     1'b0, 37,  1'b1, 2, 1);
    test_load("msg_val",    1'b0, 0,   1'b0, 0, 2);
    test_load("zero_neg",   1'b0, 0,   1'b1, 0, 0);
    test_load("ovf_1000",   1'b1, 1000, 1'b0, 0, 0);
    test_load("max_999",    1'b1, 999,  1'b0, 0, 0);
    test_load("ovf_neg_dp", 1'b1, 4095, 1'b1, 3, 0);
    test_load("w12_small",  1'b1, 40,   1'b1, 2, 0);
    test_busy_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
